// File: rtl/namuru_dump_sequencer_if.sv
// Wishbone read-master bus and output word stream of the correlator dump sequencer.
// master = sequencer side, slave = correlator bus plus stream consumer.
interface namuru_dump_sequencer_if;
  logic [31:0] m_adr_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  logic [31:0] out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output m_adr_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
    input  m_dat_i, m_ack_i,
    output out_data, out_ch, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  m_adr_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
    output m_dat_i, m_ack_i,
    input  out_data, out_ch, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/namuru_dump_sequencer.sv
// Drains STATUS, NEW_DATA and every flagged channel's accumulators/epoch after each
// accum_int rising edge, one Wishbone read at a time, into a valid/ready word FIFO.
module namuru_dump_sequencer #(
  parameter int unsigned NCH        = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] BASE       = 32'h0
) (
  input  logic                    correlator_clk,
  input  logic                    correlator_rst,
  input  logic                    enable,
  input  logic                    accum_int,
  input  logic                    clear,
  namuru_dump_sequencer_if.master bus,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err,
  output logic [7:0]              frame_cnt
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned TW        = $clog2(TIMEOUT) + 1;
  localparam logic [7:0]  W_STATUS  = 8'hE0;
  localparam logic [7:0]  W_NEWDATA = 8'hE1;

  typedef enum logic [2:0] {IDLE, RD_STATUS, RD_NEWDATA, SCAN, RD_CH, DONE} state_e;

  typedef struct packed {
    logic        last;
    logic [3:0]  ch;
    logic [31:0] data;
  } word_t;

  state_e         state_q, state_d;
  logic           cyc_q, cyc_d;
  logic [31:0]    adr_q, adr_d;
  logic [NCH-1:0] nd_mask_q, nd_mask_d;
  logic [3:0]     ch_q, ch_d;
  logic [2:0]     k_q, k_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           accum_prev_q, accum_prev_d;
  logic           overrun_q, overrun_d;
  logic           timeout_err_q, timeout_err_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  word_t          mem_q [FIFO_DEPTH];

  logic           trig, tmo_hit, push, pop, fifo_full, fifo_empty, found;
  word_t          push_word, head;
  logic [7:0]     rd_word;
  logic [3:0]     koff, low_ch;
  logic [NCH-1:0] mask_left;

  // Channel word offsets: six accumulators at 4..9, epoch at 0xC.
  always_comb begin
    koff = 4'hC;
    if (k_q < 3'd6) koff = 4'd4 + {1'b0, k_q};
  end

  always_comb begin
    case (state_q)
      RD_STATUS:  rd_word = W_STATUS;
      RD_NEWDATA: rd_word = W_NEWDATA;
      default:    rd_word = {ch_q, koff};
    endcase
  end

  always_comb begin
    found  = 1'b0;
    low_ch = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (nd_mask_q[i]) begin
        found  = 1'b1;
        low_ch = 4'(i);
      end
    end
  end

  assign mask_left  = nd_mask_q & ~(NCH'(1) << ch_q);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & bus.out_ready;
  assign trig       = accum_int & ~accum_prev_q;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    nd_mask_d    = nd_mask_q;
    ch_d         = ch_q;
    k_d          = k_q;
    tmo_d        = '0;
    accum_prev_d = accum_int;
    frame_cnt_d  = frame_cnt_q;
    tmo_hit      = 1'b0;
    push         = 1'b0;
    push_word    = '0;

    case (state_q)
      IDLE: if (trig && enable) state_d = RD_STATUS;
      RD_STATUS, RD_NEWDATA, RD_CH: begin
        if (!cyc_q) begin
          // Reads wait in place while the FIFO has no room for the answer.
          if (!fifo_full) begin
            cyc_d = 1'b1;
            adr_d = BASE + {22'd0, rd_word, 2'b00};
          end
        end else if (bus.m_ack_i) begin
          cyc_d          = 1'b0;
          push           = 1'b1;
          push_word.data = bus.m_dat_i;
          push_word.ch   = 4'hF;
          case (state_q)
            RD_STATUS: state_d = RD_NEWDATA;
            RD_NEWDATA: begin
              nd_mask_d      = bus.m_dat_i[NCH-1:0];
              push_word.last = (bus.m_dat_i[NCH-1:0] == '0);
              state_d        = SCAN;
            end
            default: begin
              push_word.ch = ch_q;
              if (k_q == 3'd6) begin
                nd_mask_d      = mask_left;
                push_word.last = (mask_left == '0);
                state_d        = SCAN;
              end else begin
                k_d = k_q + 3'd1;
              end
            end
          endcase
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      SCAN: begin
        if (found) begin
          ch_d    = low_ch;
          k_d     = '0;
          state_d = RD_CH;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    overrun_d     = clear ? 1'b0 : (overrun_q | (trig & (state_q != IDLE)));
    timeout_err_d = clear ? 1'b0 : (timeout_err_q | tmo_hit);
    if (clear) frame_cnt_d = '0;

    wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
  end

  always_ff @(posedge correlator_clk or posedge correlator_rst) begin
    if (correlator_rst) begin
      state_q       <= IDLE;
      cyc_q         <= 1'b0;
      adr_q         <= '0;
      nd_mask_q     <= '0;
      ch_q          <= '0;
      k_q           <= '0;
      tmo_q         <= '0;
      accum_prev_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      adr_q         <= adr_d;
      nd_mask_q     <= nd_mask_d;
      ch_q          <= ch_d;
      k_q           <= k_d;
      tmo_q         <= tmo_d;
      accum_prev_q  <= accum_prev_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge correlator_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : head.data;
  assign bus.out_ch    = fifo_empty ? '0 : head.ch;
  assign bus.out_last  = fifo_empty ? 1'b0 : head.last;

  assign bus.m_adr_o = adr_q;
  assign bus.m_cyc_o = cyc_q;
  assign bus.m_stb_o = cyc_q;
  assign bus.m_we_o  = 1'b0;
  assign bus.m_sel_o = 4'hF;

  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_namuru_dump_sequencer.sv
`timescale 1ns/1ps
// Bench for namuru_dump_sequencer: a behavioural Wishbone slave and a frame-level
// model predict every read address and every stream word, checked by separate monitors.
module tb_namuru_dump_sequencer;
  localparam int NCH   = 3;
  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  typedef struct packed {
    logic        last;
    logic [3:0]  ch;
    logic [31:0] data;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable, accum_int, clear;
  logic       busy, overrun, timeout_err;
  logic [7:0] frame_cnt;

  namuru_dump_sequencer_if bus();

  namuru_dump_sequencer #(
    .NCH(NCH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .BASE(32'h0)
  ) dut (
    .correlator_clk(clk),
    .correlator_rst(rst),
    .enable(enable),
    .accum_int(accum_int),
    .clear(clear),
    .bus(bus),
    .busy(busy),
    .overrun(overrun),
    .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] wb_mem [256];
  word_t       exp_q[$];
  logic [31:0] exp_adr_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_dly_max = 0;
  int          ready_mode = 1;
  int          ack_cnt = 0;
  int          fc_model = 0;
  bit          hang_en = 1'b0;
  bit          len_chk = 1'b0;
  logic [31:0] hang_adr = 32'h384;
  int          offs [7] = '{4, 5, 6, 7, 8, 9, 12};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: STATUS, NEW_DATA, then for each flagged channel in ascending
  // order its seven words; the final word of the frame carries last.
  task automatic expect_frame(input logic [31:0] st, input logic [31:0] nd);
    logic [NCH-1:0] m;
    int top;
    wb_mem[8'hE0] = st;
    wb_mem[8'hE1] = nd;
    m   = nd[NCH-1:0];
    top = -1;
    for (int c = 0; c < NCH; c++) if (m[c]) top = c;
    exp_adr_q.push_back(32'h380);
    exp_q.push_back(word_t'{1'b0, 4'hF, st});
    exp_adr_q.push_back(32'h384);
    exp_q.push_back(word_t'{(top < 0), 4'hF, nd});
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        for (int j = 0; j < 7; j++) begin
          int w;
          w = c * 16 + offs[j];
          exp_adr_q.push_back(32'(w * 4));
          exp_q.push_back(word_t'{(c == top && j == 6), 4'(c), wb_mem[w]});
        end
      end
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) wb_mem[i] = $urandom;
  endtask

  task automatic pulse_accum();
    @(posedge clk); #2 accum_int = 1'b1;
    repeat (3) @(posedge clk);
    #2 accum_int = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_q.size() == 0 && exp_adr_q.size() == 0;
    end
    chk(name, ok, 1);
  endtask

  initial begin : ready_drv
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : wb_slave
    int dly;
    int len;
    bit prev;
    logic [31:0] a0;
    dly = 0; len = 0; prev = 1'b0; a0 = '0;
    bus.m_ack_i = 1'b0;
    bus.m_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.m_ack_i = 1'b0;
      bus.m_dat_i = $urandom;
      if (rst) begin
        prev = 1'b0;
      end else if (bus.m_cyc_o && bus.m_stb_o) begin
        if (!prev) begin
          len = 0;
          a0  = bus.m_adr_o;
          dly = $urandom_range(0, ack_dly_max);
          chk("read_expected", exp_adr_q.size() > 0, 1);
          if (exp_adr_q.size() > 0) chk("read_addr", a0, exp_adr_q.pop_front());
          chk("we_sel", {bus.m_we_o, bus.m_sel_o}, 5'h0F);
        end else begin
          chk("addr_stable", bus.m_adr_o, a0);
        end
        len++;
        if (!(hang_en && a0 == hang_adr)) begin
          if (dly == 0) begin
            bus.m_ack_i = 1'b1;
            bus.m_dat_i = wb_mem[a0[9:2]];
            ack_cnt++;
          end else begin
            dly--;
          end
        end
        prev = 1'b1;
      end else begin
        if (prev && len_chk && hang_en && a0 == hang_adr) chk("timeout_len", len, TMO);
        prev = 1'b0;
      end
    end
  end

  initial begin : stream_mon
    word_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        chk("word_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("stream_word", {bus.out_last, bus.out_ch, bus.out_data}, e);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int stb_hi;
    bit ok;
    enable = 1'b1; accum_int = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_cyc_stb", {bus.m_cyc_o, bus.m_stb_o}, 0);
    chk("rst_adr", bus.m_adr_o, 0);
    chk("rst_stream", {bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Single channel with known accumulator and epoch values.
    fill_mem();
    for (int k = 0; k < 6; k++) wb_mem[4 + k] = 32'h11 + 32'(k);
    wb_mem[12] = 32'h123;
    expect_frame(32'h2, 32'h1); fc_model++;
    pulse_accum();
    wait_idle("frame_nd1_done", 500);
    chk("frame_cnt_nd1", frame_cnt, 8'(fc_model));

    // No channel flagged: NEW_DATA word ends the frame.
    fill_mem();
    expect_frame($urandom, 32'h0); fc_model++;
    pulse_accum();
    wait_idle("frame_nd0_done", 500);
    chk("frame_cnt_nd0", frame_cnt, 8'(fc_model));

    // Channels 0 and 2 flagged, channel 1 skipped.
    fill_mem();
    expect_frame($urandom, 32'h5); fc_model++;
    pulse_accum();
    wait_idle("frame_nd5_done", 800);
    chk("frame_cnt_nd5", frame_cnt, 8'(fc_model));

    for (int f = 0; f < 10; f++) begin
      ack_dly_max = $urandom_range(0, 3);
      ready_mode  = 2;
      fill_mem();
      expect_frame($urandom, $urandom); fc_model++;
      pulse_accum();
      wait_idle("rand_frame_done", 2000);
      chk("rand_frame_cnt", frame_cnt, 8'(fc_model));
      chk("rand_no_overrun", overrun, 0);
    end

    // Stream stalled: reads must stop once the FIFO holds DEPTH words.
    ack_dly_max = 0;
    ready_mode  = 0;
    @(posedge clk);
    fill_mem();
    expect_frame($urandom, 32'h1); fc_model++;
    base = ack_cnt;
    pulse_accum();
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (ack_cnt >= base + DEPTH);
    end
    chk("stall_fill_reached", ok, 1);
    stb_hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.m_stb_o) stb_hi++;
    end
    chk("stall_no_stb", stb_hi, 0);
    chk("stall_busy", busy, 1);
    ready_mode = 1;
    wait_idle("stall_frame_done", 800);
    chk("stall_frame_cnt", frame_cnt, 8'(fc_model));

    // Retrigger mid-frame flags overrun without disturbing the frame.
    ack_dly_max = 2;
    fill_mem();
    expect_frame($urandom, 32'h7); fc_model++;
    pulse_accum();
    repeat (4) @(posedge clk);
    #2 accum_int = 1'b1;
    @(negedge clk);
    chk("busy_at_retrigger", busy, 1);
    repeat (2) @(posedge clk);
    #2 accum_int = 1'b0;
    wait_idle("overrun_frame_done", 2000);
    chk("overrun_set", overrun, 1);
    chk("overrun_frame_cnt", frame_cnt, 8'(fc_model));
    pulse_clear();
    fc_model = 0;
    @(negedge clk);
    chk("clear_overrun", overrun, 0);
    chk("clear_frame_cnt", frame_cnt, 0);

    // Disabled: the edge is ignored entirely.
    enable = 1'b0;
    pulse_accum();
    repeat (20) @(negedge clk);
    chk("disabled_busy", busy, 0);
    chk("disabled_cyc", bus.m_cyc_o, 0);
    chk("disabled_overrun", overrun, 0);
    enable = 1'b1;

    // NEW_DATA read never acknowledged.
    ready_mode = 0;
    hang_en    = 1'b1;
    len_chk    = 1'b1;
    fill_mem();
    wb_mem[8'hE0] = $urandom;
    exp_adr_q.push_back(32'h380);
    exp_adr_q.push_back(32'h384);
    exp_q.push_back(word_t'{1'b0, 4'hF, wb_mem[8'hE0]});
    pulse_accum();
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = !busy && exp_adr_q.size() == 0;
    end
    chk("timeout_reached_idle", ok, 1);
    chk("timeout_err_set", timeout_err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_cyc", bus.m_cyc_o, 0);
    chk("timeout_fifo_has_status", bus.out_valid, 1);
    chk("timeout_frame_cnt", frame_cnt, 8'(fc_model));
    ready_mode = 1;
    repeat (6) @(negedge clk);
    chk("timeout_words_left", exp_q.size(), 0);
    chk("timeout_fifo_empty", bus.out_valid, 0);
    hang_en = 1'b0;
    len_chk = 1'b0;
    pulse_clear();
    @(negedge clk);
    chk("clear_timeout", timeout_err, 0);

    // Reset in the middle of a pending read with a word held in the FIFO.
    ready_mode = 0;
    hang_en    = 1'b1;
    wb_mem[8'hE0] = $urandom;
    exp_adr_q.push_back(32'h380);
    exp_adr_q.push_back(32'h384);
    exp_q.push_back(word_t'{1'b0, 4'hF, wb_mem[8'hE0]});
    pulse_accum();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.m_cyc_o && exp_adr_q.size() == 0;
    end
    chk("rst_test_in_read", ok, 1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cyc_stb", {bus.m_cyc_o, bus.m_stb_o}, 0);
    chk("async_rst_fifo", bus.out_valid, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    hang_en    = 1'b0;
    ready_mode = 1;
    fc_model   = 0;
    @(negedge clk);
    chk("post_rst_frame_cnt", frame_cnt, 0);

    fill_mem();
    expect_frame($urandom, $urandom); fc_model++;
    pulse_accum();
    wait_idle("recovery_frame_done", 2000);
    chk("recovery_frame_cnt", frame_cnt, 8'(fc_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
